// File: rtl/rv_plic_intr_coalesce_pkg.sv
// rv_plic_intr_coalesce_pkg: shared channel state encoding and default
// widths for the PLIC interrupt-source coalescer.
package rv_plic_intr_coalesce_pkg;

   // Per-channel state. IDLE waits for the first event of a window, ACCUM
   // counts events and cycles, FIRE holds the level until acknowledged.
   typedef enum logic [1:0] {
      CoalIdle  = 2'd0,
      CoalAccum = 2'd1,
      CoalFire  = 2'd2
   } coal_state_e;

   // Default event-counter / threshold width.
   localparam int unsigned CoalCntWDef = 8;

   // Default timeout-counter / timeout-value width.
   localparam int unsigned CoalTmrWDef = 16;

endpackage : rv_plic_intr_coalesce_pkg

// File: rtl/rv_plic_intr_coalesce_chan.sv
// rv_plic_intr_coalesce_chan: one interrupt-source channel. Detects rising
// edges on its event line, accumulates them in a window and raises a level
// interrupt when the count threshold or the window timeout is reached. The
// level is held until a clear pulse acknowledges it.
module rv_plic_intr_coalesce_chan
   import rv_plic_intr_coalesce_pkg::*;
#(
   parameter int unsigned CntW = CoalCntWDef,
   parameter int unsigned TmrW = CoalTmrWDef
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_evt,
   input  logic            i_en,
   input  logic [CntW-1:0] i_thresh,
   input  logic [TmrW-1:0] i_timeout,
   input  logic            i_clr,
   output logic            o_intr,
   output logic            o_ovf
);

   localparam logic [CntW-1:0] CntMax = '1;
   localparam logic [TmrW-1:0] TmrMax = '1;

   // Saturating increment of the event counter.
   function automatic logic [CntW-1:0] cnt_sat_inc(input logic [CntW-1:0] v);
      return (v == CntMax) ? v : v + CntW'(1);
   endfunction

   // Saturating increment of the window timer.
   function automatic logic [TmrW-1:0] tmr_sat_inc(input logic [TmrW-1:0] v);
      return (v == TmrMax) ? v : v + TmrW'(1);
   endfunction

   logic            r_evt_q;
   coal_state_e     r_state;
   logic [CntW-1:0] r_cnt;
   logic [TmrW-1:0] r_tmr;
   logic            r_ovf;

   coal_state_e     w_state_n;
   logic [CntW-1:0] w_cnt_n;
   logic [TmrW-1:0] w_tmr_n;
   logic            w_ovf_n;

   logic            w_edge;
   logic            w_first_fire;
   logic            w_tmr_hit;
   logic [CntW-1:0] w_cnt_acc;

   // A held-high event line counts only once.
   assign w_edge = i_evt & ~r_evt_q;

   // A window opened with threshold 0 or 1 is already complete.
   assign w_first_fire = (i_thresh <= CntW'(1));

   // Timer compare is done one bit wider so a saturated timer never
   // wraps around into a false match.
   assign w_tmr_hit = (i_timeout != '0) &&
                      (({1'b0, r_tmr} + (TmrW+1)'(1)) == {1'b0, i_timeout});

   // Count including the event sampled this cycle.
   assign w_cnt_acc = w_edge ? cnt_sat_inc(r_cnt) : r_cnt;

   // State, counters and edge history register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_evt_q <= 1'b0;
         r_state <= CoalIdle;
         r_cnt   <= '0;
         r_tmr   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_evt_q <= i_evt;
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_tmr   <= w_tmr_n;
         r_ovf   <= w_ovf_n;
      end
   end

   // Next-state and counter update for the coalescing window.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_tmr_n   = r_tmr;
      w_ovf_n   = r_ovf;

      if (!i_en) begin
         w_state_n = CoalIdle;
         w_cnt_n   = '0;
         w_tmr_n   = '0;
         w_ovf_n   = 1'b0;
      end else begin
         unique case (r_state)
            CoalIdle: begin
               if (w_edge) begin
                  w_cnt_n   = CntW'(1);
                  w_tmr_n   = '0;
                  w_state_n = w_first_fire ? CoalFire : CoalAccum;
               end
            end

            CoalAccum: begin
               w_cnt_n = w_cnt_acc;
               w_tmr_n = tmr_sat_inc(r_tmr);
               // ">=" so a threshold lowered below the current count fires.
               if ((w_cnt_acc >= i_thresh) || w_tmr_hit) begin
                  w_state_n = CoalFire;
               end
            end

            CoalFire: begin
               if (i_clr) begin
                  // Acknowledge wins; a coincident event opens a new window.
                  w_ovf_n = 1'b0;
                  if (w_edge) begin
                     w_cnt_n   = CntW'(1);
                     w_tmr_n   = '0;
                     w_state_n = w_first_fire ? CoalFire : CoalAccum;
                  end else begin
                     w_cnt_n   = '0;
                     w_tmr_n   = '0;
                     w_state_n = CoalIdle;
                  end
               end else if (w_edge) begin
                  if (r_cnt == CntMax) begin
                     w_ovf_n = 1'b1;
                  end else begin
                     w_cnt_n = r_cnt + CntW'(1);
                  end
               end
            end

            default: begin
               w_state_n = CoalIdle;
               w_cnt_n   = '0;
               w_tmr_n   = '0;
               w_ovf_n   = 1'b0;
            end
         endcase
      end
   end

   assign o_intr = (r_state == CoalFire);
   assign o_ovf  = r_ovf;

endmodule : rv_plic_intr_coalesce_chan

// File: rtl/rv_plic_intr_coalesce.sv
// rv_plic_intr_coalesce: converts raw peripheral event pulses into coalesced
// level interrupts for the PLIC source inputs, one channel per source.
// Optional build macro RV_PLIC_INTR_COAL_SYNC_EN inserts a 2-flop
// synchronizer on every event line (for asynchronous peripherals), adding
// two cycles of event-to-interrupt latency.
module rv_plic_intr_coalesce
   import rv_plic_intr_coalesce_pkg::*;
#(
   parameter int unsigned NumSrc = 32,
   parameter int unsigned CntW   = CoalCntWDef,
   parameter int unsigned TmrW   = CoalTmrWDef
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumSrc-1:0] evt_i,
   input  logic [NumSrc-1:0] en_i,
   input  logic [CntW-1:0]   thresh_i,
   input  logic [TmrW-1:0]   timeout_i,
   input  logic [NumSrc-1:0] clr_i,
   output logic [NumSrc-1:0] intr_src_o,
   output logic [NumSrc-1:0] ovf_o
);

   logic [NumSrc-1:0] w_evt;

`ifdef RV_PLIC_INTR_COAL_SYNC_EN
   logic [NumSrc-1:0] r_sync_p0;
   logic [NumSrc-1:0] r_sync_p1;

   // Two-flop synchronizer bringing asynchronous event lines into clk_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync_p0 <= '0;
         r_sync_p1 <= '0;
      end else begin
         r_sync_p0 <= evt_i;
         r_sync_p1 <= r_sync_p0;
      end
   end

   assign w_evt = r_sync_p1;
`else
   assign w_evt = evt_i;
`endif

   for (genvar g = 0; g < NumSrc; g++) begin : g_chan
      rv_plic_intr_coalesce_chan #(
         .CntW (CntW),
         .TmrW (TmrW)
      ) u_chan (
         .i_clk     (clk_i),
         .i_rst     (rst_i),
         .i_evt     (w_evt[g]),
         .i_en      (en_i[g]),
         .i_thresh  (thresh_i),
         .i_timeout (timeout_i),
         .i_clr     (clr_i[g]),
         .o_intr    (intr_src_o[g]),
         .o_ovf     (ovf_o[g])
      );
   end

endmodule : rv_plic_intr_coalesce

// File: tb/tb_rv_plic_intr_coalesce.sv
// tb_rv_plic_intr_coalesce: table-driven, sequence and randomized checks of
// the interrupt coalescer against a window/age reference model.
module tb_rv_plic_intr_coalesce;

   localparam int NS = 32;
   localparam logic [NS-1:0] ALL = '1;

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] evt;
   logic [NS-1:0] en;
   logic [NS-1:0] clr;
   logic [7:0]    thresh;
   logic [15:0]   timeout;
   logic [NS-1:0] intr;
   logic [NS-1:0] ovf;

   always #5 clk = ~clk;

   rv_plic_intr_coalesce #(
      .NumSrc (NS),
      .CntW   (8),
      .TmrW   (16)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .evt_i      (evt),
      .en_i       (en),
      .thresh_i   (thresh),
      .timeout_i  (timeout),
      .clr_i      (clr),
      .intr_src_o (intr),
      .ovf_o      (ovf)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a source is either waiting, has an open window
   // (counting events and its age in cycles), or is firing.
   bit m_fire [NS];
   bit m_open [NS];
   bit m_ovf  [NS];
   bit m_prev [NS];
   int m_cnt  [NS];
   int m_age  [NS];

   function automatic logic [NS-1:0] m_intr_v();
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) v[i] = m_fire[i];
      return v;
   endfunction

   function automatic logic [NS-1:0] m_ovf_v();
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) v[i] = m_ovf[i];
      return v;
   endfunction

   task automatic m_drop(input int i);
      m_fire[i] = 1'b0;
      m_open[i] = 1'b0;
      m_ovf[i]  = 1'b0;
      m_cnt[i]  = 0;
      m_age[i]  = 0;
   endtask

   task automatic m_open_window(input int i, input int th);
      m_cnt[i] = 1;
      m_age[i] = 0;
      if (th <= 1) m_fire[i] = 1'b1;
      else         m_open[i] = 1'b1;
   endtask

   task automatic model_edge(input logic r, input logic [NS-1:0] e,
                             input logic [NS-1:0] env, input logic [NS-1:0] c,
                             input int th, input int to);
      for (int i = 0; i < NS; i++) begin
         bit ed;
         ed = e[i] && !m_prev[i];
         if (r) begin
            m_drop(i);
            m_prev[i] = 1'b0;
         end else begin
            m_prev[i] = e[i];
            if (!env[i]) begin
               m_drop(i);
            end else if (m_fire[i]) begin
               if (c[i]) begin
                  m_drop(i);
                  if (ed) m_open_window(i, th);
               end else if (ed) begin
                  if (m_cnt[i] >= 255) m_ovf[i] = 1'b1;
                  m_cnt[i]++;
               end
            end else if (m_open[i]) begin
               m_age[i]++;
               if (ed) m_cnt[i]++;
               if ((m_cnt[i] >= th) || (to != 0 && m_age[i] == to)) begin
                  m_open[i] = 1'b0;
                  m_fire[i] = 1'b1;
               end
            end else if (ed) begin
               m_open_window(i, th);
            end
         end
      end
   endtask

   task automatic check(input string nm, input logic [NS-1:0] ai, input logic [NS-1:0] ao,
                        input logic [NS-1:0] ei, input logic [NS-1:0] eo);
      n_vec++;
      if (ai !== ei || ao !== eo) begin
         n_err++;
         $display("FAIL %s: got intr=%h ovf=%h, want intr=%h ovf=%h", nm, ai, ao, ei, eo);
      end
   endtask

   // Apply one cycle of inputs, advance past the edge, check against the model.
   task automatic step(input logic r, input logic [NS-1:0] e, input logic [NS-1:0] env,
                       input logic [NS-1:0] c, input logic [7:0] th, input logic [15:0] to);
      rst     = r;
      evt     = e;
      en      = env;
      clr     = c;
      thresh  = th;
      timeout = to;
      @(posedge clk);
      #1;
      model_edge(r, e, env, c, int'(th), int'(to));
      check("model", intr, ovf, m_intr_v(), m_ovf_v());
   endtask

   typedef struct {
      logic          rst;
      logic [NS-1:0] evt;
      logic [NS-1:0] en;
      logic [NS-1:0] clr;
      logic [7:0]    th;
      logic [15:0]   to;
      logic [NS-1:0] x_intr;
      logic [NS-1:0] x_ovf;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [NS-1:0] e, input logic [NS-1:0] env,
                               input logic [NS-1:0] c, input logic [7:0] th,
                               input logic [NS-1:0] xi);
      vec_t v;
      v.rst = r; v.evt = e; v.en = env; v.clr = c; v.th = th; v.to = 16'd0;
      v.x_intr = xi; v.x_ovf = '0;
      return v;
   endfunction

   vec_t tbl [27];

   initial begin
      // Cycle-by-cycle vectors; expected outputs are after the applied edge.
      tbl[0]  = mk(1'b1, 32'h0, ALL,     32'h0, 8'd1, 32'h0);  // reset
      tbl[1]  = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h0);
      tbl[2]  = mk(1'b0, 32'h8, ALL,     32'h0, 8'd1, 32'h8);  // thresh 1 fires next cycle
      tbl[3]  = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h8);
      tbl[4]  = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h8);
      tbl[5]  = mk(1'b0, 32'h0, ALL,     32'h8, 8'd1, 32'h0);  // clear
      tbl[6]  = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h0);
      tbl[7]  = mk(1'b0, 32'h1, ALL,     32'h0, 8'd4, 32'h0);  // cnt 1
      tbl[8]  = mk(1'b0, 32'h0, ALL,     32'h0, 8'd4, 32'h0);
      tbl[9]  = mk(1'b0, 32'h1, ALL,     32'h0, 8'd4, 32'h0);  // cnt 2
      tbl[10] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd4, 32'h0);
      tbl[11] = mk(1'b0, 32'h1, ALL,     32'h0, 8'd4, 32'h0);  // cnt 3
      tbl[12] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd4, 32'h0);
      tbl[13] = mk(1'b0, 32'h1, ALL,     32'h0, 8'd4, 32'h1);  // cnt 4 fires
      tbl[14] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd4, 32'h1);
      tbl[15] = mk(1'b0, 32'h1, ALL,     32'h1, 8'd4, 32'h0);  // clr+evt, thresh 4 -> accum
      tbl[16] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd4, 32'h0);
      tbl[17] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h1);  // lowered thresh fires
      tbl[18] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h1);
      tbl[19] = mk(1'b0, 32'h1, ALL,     32'h1, 8'd1, 32'h1);  // clr+evt, thresh 1 -> refire
      tbl[20] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h1);
      tbl[21] = mk(1'b0, 32'h0, ~32'h1,  32'h0, 8'd1, 32'h0);  // disable in fire
      tbl[22] = mk(1'b0, 32'h1, ~32'h1,  32'h0, 8'd1, 32'h0);  // ignored while disabled
      tbl[23] = mk(1'b0, 32'h1, ALL,     32'h0, 8'd1, 32'h0);  // still high: no edge
      tbl[24] = mk(1'b0, 32'h0, ALL,     32'h0, 8'd1, 32'h0);
      tbl[25] = mk(1'b0, 32'h1, ALL,     32'h0, 8'd1, 32'h1);
      tbl[26] = mk(1'b1, 32'h0, ALL,     32'h0, 8'd1, 32'h0);  // reset clears

      for (int k = 0; k < 27; k++) begin
         step(tbl[k].rst, tbl[k].evt, tbl[k].en, tbl[k].clr, tbl[k].th, tbl[k].to);
         check($sformatf("vec%0d", k), intr, ovf, tbl[k].x_intr, tbl[k].x_ovf);
      end

      // Timeout: held-high event on src 5 counts once, fires 10 cycles later.
      step(1'b1, '0, ALL, '0, 8'd4, 16'd10);
      for (int k = 0; k < 12; k++) begin
         step(1'b0, (k < 8) ? 32'h20 : 32'h0, ALL, '0, 8'd4, 16'd10);
         check($sformatf("timeout_k%0d", k), intr, ovf, (k >= 10) ? 32'h20 : 32'h0, 32'h0);
      end

      // Counter saturation and sticky overflow on src 7.
      step(1'b1, '0, ALL, '0, 8'd1, 16'd0);
      for (int p = 1; p <= 300; p++) begin
         step(1'b0, 32'h80, ALL, '0, 8'd1, 16'd0);
         if (p == 255) check("ovf_p255", intr, ovf, 32'h80, 32'h0);
         if (p == 256) check("ovf_p256", intr, ovf, 32'h80, 32'h80);
         step(1'b0, 32'h0, ALL, '0, 8'd1, 16'd0);
      end
      check("ovf_p300", intr, ovf, 32'h80, 32'h80);
      step(1'b0, 32'h0, ALL, 32'h80, 8'd1, 16'd0);
      check("ovf_clr", intr, ovf, 32'h0, 32'h0);

      // Reset mid-window and disable in FIRE on src 2 (thresh 3).
      step(1'b0, 32'h4, ALL, '0, 8'd3, 16'd0);
      step(1'b0, 32'h0, ALL, '0, 8'd3, 16'd0);
      step(1'b0, 32'h4, ALL, '0, 8'd3, 16'd0);
      step(1'b0, 32'h0, ALL, '0, 8'd3, 16'd0);
      check("accum_cnt2", intr, ovf, 32'h0, 32'h0);
      step(1'b1, 32'h0, ALL, '0, 8'd3, 16'd0);
      check("rst_mid_accum", intr, ovf, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 32'h4, ALL, '0, 8'd3, 16'd0);
         step(1'b0, 32'h0, ALL, '0, 8'd3, 16'd0);
      end
      check("restart_cnt2", intr, ovf, 32'h0, 32'h0);
      step(1'b0, 32'h4, ALL, '0, 8'd3, 16'd0);
      check("restart_fire", intr, ovf, 32'h4, 32'h0);
      step(1'b0, 32'h0, ~32'h4, '0, 8'd3, 16'd0);
      check("disable_fire", intr, ovf, 32'h0, 32'h0);
      step(1'b0, 32'h4, ALL, '0, 8'd3, 16'd0);
      check("reen_cnt1", intr, ovf, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 32'h0, ALL, '0, 8'd3, 16'd0);
         step(1'b0, 32'h4, ALL, '0, 8'd3, 16'd0);
      end
      check("reen_fire", intr, ovf, 32'h4, 32'h0);

      // Randomized traffic against the model.
      begin
         logic [7:0]  rth;
         logic [15:0] rto;
         rth = 8'd2;
         rto = 16'd0;
         for (int c = 0; c < 3000; c++) begin
            logic [NS-1:0] e;
            logic [NS-1:0] env;
            logic [NS-1:0] cl;
            logic          r;
            if ($urandom_range(0, 49) == 0) rth = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) rto = 16'($urandom_range(0, 15));
            e   = $urandom() & $urandom();
            env = ($urandom_range(0, 19) == 0) ? NS'($urandom()) : ALL;
            cl  = $urandom() & $urandom() & $urandom();
            r   = ($urandom_range(0, 499) == 0);
            step(r, e, env, cl, rth, rto);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_rv_plic_intr_coalesce
